// File: rtl/trans.sv
// UART transmitter: serialises one word per request onto the TX line.
// Shares tick, frame-size, parity and stop encodings with the receiver.
module trans #(
  parameter int SIZE_DATA     = 9,
  parameter int OVER_SAMPLING = 16
) (
  input  logic                 i_clk,
  input  logic                 i_rst_n,
  input  logic                 i_stick,
  input  logic                 i_tx_en,
  input  logic                 i_start,
  input  logic [SIZE_DATA-1:0] i_data,
  input  logic [2:0]           i_size_frame,
  input  logic [1:0]           i_parity_bit,
  input  logic                 i_stop_bit,
  output logic                 o_tx,
  output logic                 o_ready,
  output logic                 o_busy,
  output logic                 o_done_tx
);

  localparam int CW = $clog2(OVER_SAMPLING);
  localparam int IW = $clog2(SIZE_DATA + 1);

  localparam logic [2:0] IDLE   = 3'd0;
  localparam logic [2:0] START  = 3'd1;
  localparam logic [2:0] DATA   = 3'd2;
  localparam logic [2:0] PARITY = 3'd3;
  localparam logic [2:0] STOP_1 = 3'd4;
  localparam logic [2:0] STOP_2 = 3'd5;
  localparam logic [2:0] DONE   = 3'd6;

  logic [2:0]           state;
  logic [2:0]           nxt;
  logic [CW-1:0]        cnt;
  logic [IW-1:0]        idx;
  logic [IW-1:0]        last;
  logic [IW-1:0]        last_in;
  logic [SIZE_DATA-1:0] shreg;
  logic [SIZE_DATA-1:0] mask;
  logic                 par_en;
  logic                 par_val;
  logic                 stop2;
  logic                 tx;
  logic                 tx_nxt;
  logic                 tick_end;
  logic                 accept;

  assign tick_end = i_stick && (cnt == CW'(OVER_SAMPLING - 1));
  assign accept   = (state == IDLE) && i_start && i_tx_en;

  // last_in holds the index of the final payload bit (N-1)
  always_comb begin
    last_in = IW'(7);
    unique case (i_size_frame)
      3'b000:  last_in = IW'(4);
      3'b001:  last_in = IW'(5);
      3'b010:  last_in = IW'(6);
      3'b011:  last_in = IW'(7);
      3'b100:  last_in = IW'(8);
      default: last_in = IW'(7);
    endcase
  end

  always_comb begin
    mask = '0;
    for (int i = 0; i < SIZE_DATA; i++)
      mask[i] = (i <= int'(last_in));
  end

  always_comb begin
    nxt = state;
    unique case (state)
      IDLE:    if (accept) nxt = START;
      START:   if (tick_end) nxt = DATA;
      DATA:
        if (tick_end && idx == last)
          nxt = par_en ? PARITY : STOP_1;
      PARITY:  if (tick_end) nxt = STOP_1;
      STOP_1:
        if (tick_end)
          nxt = stop2 ? STOP_2 : DONE;
      STOP_2:  if (tick_end) nxt = DONE;
      DONE:    nxt = IDLE;
      default: nxt = IDLE;
    endcase
  end

  always_comb begin
    tx_nxt = 1'b1;
    unique case (state)
      START:   tx_nxt = 1'b0;
      DATA:    tx_nxt = shreg[0];
      PARITY:  tx_nxt = par_val;
      default: tx_nxt = 1'b1;
    endcase
  end

  always_ff @(posedge i_clk or negedge i_rst_n) begin
    if (!i_rst_n) begin
      state   <= IDLE;
      tx      <= 1'b1;
      cnt     <= '0;
      idx     <= '0;
      last    <= '0;
      shreg   <= '0;
      par_en  <= 1'b0;
      par_val <= 1'b0;
      stop2   <= 1'b0;
    end else begin
      state <= nxt;
      tx    <= tx_nxt;
      // parity is folded in at acceptance; odd mode inverts the XOR
      if (accept) begin
        shreg   <= i_data;
        last    <= last_in;
        par_en  <= ^i_parity_bit;
        par_val <= (^(i_data & mask)) ^ i_parity_bit[0];
        stop2   <= i_stop_bit;
      end
      if (state == IDLE || state == DONE) begin
        cnt <= '0;
        idx <= '0;
      end else if (i_stick) begin
        cnt <= tick_end ? '0 : cnt + CW'(1);
        if (state == DATA && tick_end) begin
          idx   <= idx + IW'(1);
          shreg <= shreg >> 1;
        end
      end
    end
  end

  assign o_tx      = tx;
  assign o_ready   = (state == IDLE);
  assign o_busy    = (state != IDLE);
  assign o_done_tx = (state == DONE);

endmodule

// File: tb/tb_trans.sv
// Directed bench for trans: decodes o_tx mid-bit and
// compares frames, timing and handshakes with hand values.
module tb_trans;

  logic       clk;
  logic       rst_n;
  logic       stick;
  logic       tx_en;
  logic       start;
  logic [8:0] data;
  logic [2:0] size;
  logic [1:0] par;
  logic       stop;
  logic       tx;
  logic       ready;
  logic       busy;
  logic       done;

  int checks = 0;
  int errors = 0;
  int cyc    = 0;
  int ndone  = 0;
  int acc    = 0;
  int div    = 1;
  int sc     = 0;
  logic [15:0] last_cap;

  trans dut (
    .i_clk        (clk),
    .i_rst_n      (rst_n),
    .i_stick      (stick),
    .i_tx_en      (tx_en),
    .i_start      (start),
    .i_data       (data),
    .i_size_frame (size),
    .i_parity_bit (par),
    .i_stop_bit   (stop),
    .o_tx         (tx),
    .o_ready      (ready),
    .o_busy       (busy),
    .o_done_tx    (done)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  always @(posedge clk) cyc <= cyc + 1;

  always @(negedge clk) if (done) ndone <= ndone + 1;

  always @(negedge clk) begin
    sc = (sc + 1 >= div) ? 0 : sc + 1;
    stick = (sc == 0);
  end

  task automatic chk(input string tag,
                     input logic [31:0] got,
                     input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s got %0h exp %0h", tag, got, exp);
    end
  endtask

  task automatic req(input logic [8:0] d, input logic [2:0] sz,
                     input logic [1:0] p, input logic sb);
    @(negedge clk);
    data  = d;
    size  = sz;
    par   = p;
    stop  = sb;
    start = 1'b1;
    @(negedge clk);
    start = 1'b0;
    acc   = cyc;
  endtask

  task automatic rx(input string tag, input int per, input int nb,
                    input logic [15:0] exp_bits, input int exp_dur);
    logic [15:0] cap;
    int w;
    cap = '0;
    w = 0;
    while (tx !== 1'b0 && w < 4000) begin
      @(negedge clk);
      w++;
    end
    chk({tag, "_start"}, 32'(w < 4000), 32'd1);
    repeat (per / 2) @(negedge clk);
    for (int k = 0; k < nb; k++) begin
      cap[k] = tx;
      if (k < nb - 1) repeat (per) @(negedge clk);
    end
    chk({tag, "_bits"}, 32'(cap), 32'(exp_bits));
    w = 0;
    while (done !== 1'b1 && w < 4000) begin
      @(negedge clk);
      w++;
    end
    chk({tag, "_done"}, 32'(w < 4000), 32'd1);
    chk({tag, "_busy_done"}, 32'(busy), 32'd1);
    chk({tag, "_tx_done"}, 32'(tx), 32'd1);
    if (exp_dur > 0)
      chk({tag, "_dur"}, 32'(cyc - acc), 32'(exp_dur));
    @(negedge clk);
    chk({tag, "_ready"}, 32'(ready), 32'd1);
    last_cap = cap;
  endtask

  initial begin : main
    int n;
    int b;
    int w;
    rst_n = 1'b0;
    tx_en = 1'b1;
    start = 1'b0;
    data  = '0;
    size  = 3'b011;
    par   = 2'b00;
    stop  = 1'b0;
    repeat (3) @(negedge clk);
    chk("rst_tx", 32'(tx), 32'd1);
    chk("rst_ready", 32'(ready), 32'd1);
    chk("rst_busy", 32'(busy), 32'd0);
    chk("rst_done", 32'(done), 32'd0);
    rst_n = 1'b1;
    repeat (2) @(negedge clk);

    n = ndone;
    req(9'h0A5, 3'b011, 2'b00, 1'b0);
    rx("8n1", 16, 10, 16'h034A, 160);
    repeat (5) @(negedge clk);
    chk("8n1_once", 32'(ndone - n), 32'd1);

    req(9'h1F3, 3'b000, 2'b10, 1'b0);
    rx("5e1", 16, 8, 16'h00E6, 128);

    req(9'h100, 3'b100, 2'b01, 1'b1);
    rx("9o2", 16, 13, 16'h1A00, 208);

    div = 4;
    fork
      begin
        req(9'h041, 3'b010, 2'b10, 1'b0);
        rx("7e1", 64, 10, 16'h0282, 0);
      end
      begin
        repeat (200) @(negedge clk);
        size  = 3'b000;
        data  = 9'h000;
        start = 1'b1;
        @(negedge clk);
        start = 1'b0;
      end
    join
    b = 0;
    repeat (100) begin
      @(negedge clk);
      if (busy) b++;
    end
    chk("7e1_no_queue", 32'(b), 32'd0);
    div = 1;

    tx_en = 1'b0;
    data  = 9'h0FF;
    start = 1'b1;
    repeat (20) @(negedge clk);
    chk("en_off_ready", 32'(ready), 32'd1);
    chk("en_off_tx", 32'(tx), 32'd1);
    chk("en_off_busy", 32'(busy), 32'd0);
    start = 1'b0;
    tx_en = 1'b1;

    fork
      begin
        req(9'h155, 3'b111, 2'b00, 1'b0);
        rx("en_drop", 16, 10, 16'h02AA, 160);
      end
      begin
        repeat (40) @(negedge clk);
        tx_en = 1'b0;
      end
    join
    tx_en = 1'b1;

    n = ndone;
    req(9'h003, 3'b011, 2'b10, 1'b0);
    w = 0;
    while (tx !== 1'b0 && w < 4000) begin
      @(negedge clk);
      w++;
    end
    chk("rst_mid_start", 32'(w < 4000), 32'd1);
    repeat (150) @(negedge clk);
    chk("rst_mid_par", 32'(tx), 32'd0);
    chk("rst_mid_busy", 32'(busy), 32'd1);
    rst_n = 1'b0;
    #1;
    chk("rst_async_tx", 32'(tx), 32'd1);
    chk("rst_async_busy", 32'(busy), 32'd0);
    chk("rst_async_ready", 32'(ready), 32'd1);
    repeat (3) @(negedge clk);
    rst_n = 1'b1;
    repeat (2) @(negedge clk);
    chk("rst_no_done", 32'(ndone - n), 32'd0);

    req(9'h03C, 3'b011, 2'b00, 1'b0);
    rx("post_rst", 16, 10, 16'h0278, 160);
    chk("loop_word", 32'(last_cap[8:1]), 32'h3C);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
